// File: rtl/adc_spi_sampler_if.sv
// adc_spi_sampler_if: SPI pins to the ADC plus the sample stream to the filter.
// Ports: master = sampler side (drives SCLK/CSn/MOSI and sample outputs, reads MISO);
//        slave  = ADC/consumer side (drives MISO, observes everything else).
interface adc_spi_sampler_if;
    logic       SCLK;
    logic       CSn;
    logic       MOSI;
    logic       MISO;
    logic [9:0] DataOut;
    logic       DataValid;
    logic       NullErr;
    logic [2:0] ChanOut;

    modport master (
        output SCLK, CSn, MOSI,
        output DataOut, DataValid, NullErr, ChanOut,
        input  MISO
    );

    modport slave (
        input  SCLK, CSn, MOSI,
        input  DataOut, DataValid, NullErr, ChanOut,
        output MISO
    );
endinterface

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodic MCP3008-style SPI (mode 0) read, offset-binary to signed.
// Ports: clk, rst (async, active high); bus (master): SCLK/CSn/MOSI/MISO to the ADC,
//        DataOut/DataValid/NullErr/ChanOut to the filter.
// Option: define ADC_CHANNEL_SCAN_EN to step through channels 0..7 frame by frame.
module adc_spi_sampler #(
    parameter int ClkDiv         = 4,
    parameter int SampleInterval = 5000,
    parameter int Channel        = 0
) (
    input  logic              clk,
    input  logic              rst,
    adc_spi_sampler_if.master bus
);
    localparam int CW = (SampleInterval > 1) ? $clog2(SampleInterval) : 1;
    localparam int PW = $clog2(2 * ClkDiv);

    localparam logic [CW-1:0] CNT_LAST  = CW'(SampleInterval - 1);
    localparam logic [PW-1:0] HALF_LAST = PW'(ClkDiv - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(2 * ClkDiv - 1);
    // edge_q is the zero-based SCLK period index
    localparam logic [4:0]    EDGE_NULL = 5'd6;
    localparam logic [4:0]    EDGE_LAST = 5'd16;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [4:0]    edge_q, edge_d;
    logic [10:0]   sh_q, sh_d;
    logic [9:0]    dout_q, dout_d;
    logic          null_q, null_d;

    logic          tick;
    logic          high;
    logic          sample;
    logic [2:0]    chan;
    logic [4:0]    mosi_idx;
    logic          mosi;

    assign tick   = (cnt_q == CNT_LAST);
    assign cnt_d  = tick ? '0 : cnt_q + CW'(1);
    assign high   = (state_q == SHIFT) && (ph_q <= HALF_LAST);
    // MISO is taken on the first clk of each high phase, from the null bit onward
    assign sample = high && (ph_q == '0) && (edge_q >= EDGE_NULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            edge_q  <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            null_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            edge_q  <= edge_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            null_q  <= null_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        edge_d  = edge_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        null_d  = null_q;
        if (sample) begin
            sh_d = {sh_q[9:0], bus.MISO};
        end
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SETUP;
                    ph_d    = '0;
                end
            end
            SETUP: begin
                if (ph_q == HALF_LAST) begin
                    state_d = SHIFT;
                    ph_d    = '0;
                    edge_d  = '0;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            SHIFT: begin
                // Frame ends on the 17th falling edge; the last low phase is DONE.
                // sh_d already holds B0 even when it is sampled this very cycle.
                if (edge_q == EDGE_LAST && ph_q == HALF_LAST) begin
                    state_d = DONE;
                    dout_d  = {~sh_d[9], sh_d[8:0]};
                    null_d  = sh_d[10];
                end else if (ph_q == PER_LAST) begin
                    ph_d   = '0;
                    edge_d = edge_q + 5'd1;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bit presented for rising edge k: start, SGL, C2, C1, C0, then zeros.
    // In the low phase MOSI already shows the bit for the next rising edge.
    always_comb begin
        mosi     = 1'b0;
        mosi_idx = high ? edge_q + 5'd1 : edge_q + 5'd2;
        if (state_q == SETUP) begin
            mosi = 1'b1;
        end else if (state_q == SHIFT) begin
            case (mosi_idx)
                5'd1, 5'd2: mosi = 1'b1;
                5'd3:       mosi = chan[2];
                5'd4:       mosi = chan[1];
                5'd5:       mosi = chan[0];
                default:    mosi = 1'b0;
            endcase
        end
    end

`ifdef ADC_CHANNEL_SCAN_EN
    logic [2:0] chan_q, chan_d;
    logic [2:0] cout_q, cout_d;

    assign chan_d = (state_q == DONE) ? chan_q + 3'd1 : chan_q;
    assign cout_d = (state_q == DONE) ? chan_q : cout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_q <= '0;
            cout_q <= '0;
        end else begin
            chan_q <= chan_d;
            cout_q <= cout_d;
        end
    end

    assign chan        = chan_q;
    assign bus.ChanOut = cout_q;
`else
    assign chan        = 3'(Channel);
    assign bus.ChanOut = 3'(Channel);
`endif

    assign bus.SCLK      = high;
    assign bus.CSn       = !(state_q == SETUP || state_q == SHIFT);
    assign bus.MOSI      = mosi;
    assign bus.DataOut   = dout_q;
    assign bus.DataValid = (state_q == DONE);
    assign bus.NullErr   = (state_q == DONE) && null_q;
endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: behavioural ADC on the SPI pins, table + random frames,
// mid-frame reset abort. Expected samples are raw - 512 computed arithmetically.
module tb_adc_spi_sampler;
    localparam int CD     = 2;
    localparam int SI     = 100;
    localparam int CH     = 5;
    localparam int LOWLEN = 34 * CD;

    logic clk = 1'b0;
    logic rst;

    adc_spi_sampler_if bus ();

    adc_spi_sampler #(
        .ClkDiv        (CD),
        .SampleInterval(SI),
        .Channel       (CH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int dv_cnt = 0;

    // ADC model state
    logic [9:0] m_word = '0;
    logic       m_null = 1'b0;
    int         edge_n = 0;
    logic       mosi_q[$];
    logic [2:0] exp_ch;

    typedef struct {
        logic [9:0] raw;
        logic       nb;
        logic [9:0] exp_out;
    } vec_t;

    vec_t vec[6];

    function automatic logic adc_bit(int k);
        if (k == 7) return m_null;
        if (k >= 8 && k <= 17) return m_word[17 - k];
        return 1'b0;
    endfunction

    // CSn fall starts a frame; SCLK rises are counted and MOSI captured
    always @(negedge bus.CSn or posedge bus.SCLK) begin
        if (!bus.SCLK) begin
            edge_n = 0;
            mosi_q.delete();
        end else if (!bus.CSn) begin
            edge_n++;
            if (edge_n <= 5) mosi_q.push_back(bus.MOSI);
        end
    end

    // Mode 0: ADC shifts out the next bit after each falling SCLK
    always @(negedge bus.SCLK) begin
        bus.MISO = adc_bit(edge_n + 1);
    end

    always @(negedge clk) begin
        if (bus.DataValid) dv_cnt++;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic [9:0] w, input logic nb,
                             input logic [9:0] exp_out);
        bit         seen;
        int         low;
        logic [4:0] mw;
        m_word = w;
        m_null = nb;
        seen   = 0;
        for (int i = 0; i < 3 * SI && !seen; i++) begin
            @(negedge clk);
            if (!bus.CSn) seen = 1;
        end
        check("cs_fall", 32'(seen), 1);
        if (!seen) return;
        low = 0;
        while (!bus.CSn && low < 2 * LOWLEN) begin
            low++;
            @(negedge clk);
        end
        mw = '0;
        foreach (mosi_q[i]) mw = {mw[3:0], mosi_q[i]};
        check("cs_low_len", low, LOWLEN);
        check("dv_at_done", 32'(bus.DataValid), 1);
        check("sclk_at_done", 32'(bus.SCLK), 0);
        check("data", 32'(bus.DataOut), 32'(exp_out));
        check("null", 32'(bus.NullErr), 32'(nb));
        check("chan_out", 32'(bus.ChanOut), 32'(exp_ch));
        check("sclk_rises", edge_n, 17);
        check("mosi_cmd", 32'(mw), 32'({2'b11, exp_ch}));
        @(negedge clk);
        check("dv_one_clk", 32'(bus.DataValid), 0);
        check("null_one_clk", 32'(bus.NullErr), 0);
        check("data_hold", 32'(bus.DataOut), 32'(exp_out));
`ifdef ADC_CHANNEL_SCAN_EN
        exp_ch = exp_ch + 3'd1;
`endif
    endtask

    initial begin
        #(20000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] w;
        logic       nb;
        bit         seen;
        int         dv0;

`ifdef ADC_CHANNEL_SCAN_EN
        exp_ch = 3'd0;
`else
        exp_ch = 3'(CH);
`endif
        vec[0] = '{10'h3FF, 1'b0, 10'h1FF};
        vec[1] = '{10'h000, 1'b0, 10'h200};
        vec[2] = '{10'h200, 1'b0, 10'h000};
        vec[3] = '{10'h155, 1'b1, 10'h355};
        vec[4] = '{10'h1FF, 1'b0, 10'h3FF};
        vec[5] = '{10'h0AA, 1'b1, 10'h2AA};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_csn", 32'(bus.CSn), 1);
        check("rst_sclk", 32'(bus.SCLK), 0);
        check("rst_mosi", 32'(bus.MOSI), 0);
        check("rst_data", 32'(bus.DataOut), 0);
        check("rst_dv", 32'(bus.DataValid), 0);
        check("rst_null", 32'(bus.NullErr), 0);
        check("rst_chan", 32'(bus.ChanOut), 32'(exp_ch));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_frame(vec[i].raw, vec[i].nb, vec[i].exp_out);
        end

        for (int i = 0; i < 8; i++) begin
            w  = 10'($urandom_range(0, 1023));
            nb = ($urandom_range(0, 3) == 0);
            run_frame(w, nb, 10'(int'(w) - 512));
        end

        // Abort a frame at rising SCLK edge 10
        m_word = 10'h2C3;
        m_null = 1'b0;
        seen   = 0;
        for (int i = 0; i < 3 * SI && !seen; i++) begin
            @(negedge clk);
            if (!bus.CSn && edge_n == 10) seen = 1;
        end
        check("reach_edge10", 32'(seen), 1);
        dv0 = dv_cnt;
        #1 rst = 1'b1;
        #1;
        check("abort_csn", 32'(bus.CSn), 1);
        check("abort_sclk", 32'(bus.SCLK), 0);
        check("abort_mosi", 32'(bus.MOSI), 0);
        check("abort_dv", 32'(bus.DataValid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef ADC_CHANNEL_SCAN_EN
        exp_ch = 3'd0;
`endif
        repeat (80) @(negedge clk);
        check("abort_no_dv", dv_cnt, dv0);
        check("abort_data_clr", 32'(bus.DataOut), 0);
        check("abort_csn_idle", 32'(bus.CSn), 1);

        run_frame(10'h3A5, 1'b0, 10'h1A5);
        run_frame(10'h05A, 1'b1, 10'h25A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
